div_req_arbiter: RTL and testbench

Round-robin arbiter that shares the divider's single input FIFO among NUM_REQ requesters. Each cycle it grants at most one requester, forwards that requester's operand word, tagged with its ID, to the FIFO write port, and advances its rotating priority pointer. When enabled, it enforces a per-requester cap on operations in flight, which it tracks from the divider's result-return pulses.

---
 rtl/div_req_arbiter.sv | 129 ++++++++++++
 tb/tb_div_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_arbiter.sv
// Round-robin arbiter feeding the divider input FIFO with {id, operand} words.
// Define DIV_ARB_CREDIT_EN to add per-requester outstanding-op caps, busy_o and err_o.
module div_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 65,
    parameter int ID_WIDTH        = 2,
    parameter int MAX_OUTSTANDING = 3,
    parameter int CNT_WIDTH       = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             fifo_valid_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]   fifo_data_o,
    input  logic                             fifo_nfull_i,
    input  logic                             resp_valid_i,
    input  logic [ID_WIDTH-1:0]              resp_id_i,
    output logic                             busy_o,
    output logic                             err_o
);

    // Handshake: fifo_valid_o may be high while fifo_nfull_i is low (stalled
    // grant); a word moves only when both are high, and only then does the
    // granted requester see req_ready_o.
    logic [ID_WIDTH-1:0]   last_ptr;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   hi_idx;
    logic [ID_WIDTH-1:0]   lo_idx;
    logic                  hi_found;
    logic                  lo_found;
    logic                  grant_any;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    // Indices above last_ptr win first; otherwise wrap to the lowest eligible.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hi_found && eligible[i] && (ID_WIDTH'(i) > last_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ID_WIDTH'(i);
            end
            if (!lo_found && eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_WIDTH'(i);
            end
        end
        grant_any = hi_found | lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign xfer         = grant_any & fifo_nfull_i;
    assign fifo_valid_o = grant_any;
    assign fifo_data_o  = grant_any ? {grant_idx, sel_data} : '0;
    assign req_ready_o  = xfer ? grant : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_ptr <= ID_WIDTH'(NUM_REQ - 1);
        end else if (xfer) begin
            last_ptr <= grant_idx;
        end
    end

`ifdef DIV_ARB_CREDIT_EN
    logic [CNT_WIDTH-1:0] out_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]   dec;
    logic [NUM_REQ-1:0]   cnt_nz;
    logic                 resp_bad;
    logic                 err_q;

    always_comb begin
        dec      = '0;
        cnt_nz   = '0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dec[i]      = resp_valid_i && (resp_id_i == ID_WIDTH'(i));
            cnt_nz[i]   = (out_cnt[i] != '0);
            eligible[i] = req_valid_i[i] && (out_cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
        // A response for an unknown id or an idle requester is a protocol error.
        resp_bad = (resp_valid_i && (32'(resp_id_i) >= NUM_REQ)) || (|(dec & ~cnt_nz));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_o[i] && !dec[i]) begin
                    out_cnt[i] <= out_cnt[i] + CNT_WIDTH'(1);
                end else if (dec[i] && !req_ready_o[i] && cnt_nz[i]) begin
                    out_cnt[i] <= out_cnt[i] - CNT_WIDTH'(1);
                end
            end
            if (resp_bad) err_q <= 1'b1;
        end
    end

    assign busy_o = |cnt_nz;
    assign err_o  = err_q;
`else
    logic                 unused_resp;
    logic [CNT_WIDTH-1:0] unused_cap;

    assign eligible    = req_valid_i;
    assign unused_resp = ^{resp_valid_i, resp_id_i};
    assign unused_cap  = CNT_WIDTH'(MAX_OUTSTANDING);
    assign busy_o      = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_div_req_arbiter.sv
// Self-checking bench for div_req_arbiter: spec-level model compared every cycle
// plus directed literal expectations for reset, fairness, back-pressure and credits.
module tb_div_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 65;
    localparam int IW = 2;
    localparam int MO = 3;
    localparam int CW = 2;
`ifdef DIV_ARB_CREDIT_EN
    localparam bit CREDIT = 1'b1;
`else
    localparam bit CREDIT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_valid;
    logic [IW+DW-1:0]  fifo_data;
    logic              fifo_nfull;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic              busy;
    logic              err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] dvals [NR];
    logic [IW-1:0] exp_q[$];

    int m_ptr;
    int m_cnt [NR];
    bit m_err;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    div_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .fifo_valid_o(fifo_valid),
        .fifo_data_o(fifo_data),
        .fifo_nfull_i(fifo_nfull),
        .resp_valid_i(resp_valid),
        .resp_id_i(resp_id),
        .busy_o(busy),
        .err_o(err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and returns mid-cycle so outputs can be read.
    task automatic drive(input logic [NR-1:0] v, input logic nf, input logic rv, input int rid);
        @(negedge clk);
        #1;
        req_valid  = v;
        fifo_nfull = nf;
        resp_valid = rv;
        resp_id    = IW'(rid);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        model_on = 1'b0;
        rst_n    = 1'b0;
        m_ptr    = NR - 1;
        m_err    = 1'b0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        req_valid  = '0;
        fifo_nfull = 1'b0;
        resp_valid = 1'b0;
        resp_id    = '0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        model_on = 1'b1;
    endtask

    task automatic set_data();
        for (int i = 0; i < NR; i++) begin
            dvals[i] = {1'b1, $urandom_range(0, 32'hFFFF_FFFF), 28'(i), 4'(i + 1)};
            req_data[i*DW +: DW] = dvals[i];
        end
    endtask

    // Spec-level model: round-robin search from the last winner, credits as integer counts.
    always begin
        int          idx;
        int          j;
        bit          xfer;
        bit          m_busy;
        logic [IW+DW-1:0] e_data;
        logic [NR-1:0]    e_ready;
        @(negedge clk);
        #2;
        if (model_on) begin
            idx = -1;
            for (int k = 1; k <= NR; k++) begin
                j = (m_ptr + k) % NR;
                if (idx < 0 && req_valid[j] && (!CREDIT || m_cnt[j] < MO)) idx = j;
            end
            m_busy = 1'b0;
            for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) m_busy = 1'b1;
            e_data  = (idx >= 0) ? {IW'(idx), dvals[idx]} : '0;
            e_ready = (idx >= 0 && fifo_nfull) ? (NR'(1) << idx) : '0;
            chk("m_fifo_valid", 128'(fifo_valid), 128'(idx >= 0));
            chk("m_fifo_data", 128'(fifo_data), 128'(e_data));
            chk("m_req_ready", 128'(req_ready), 128'(e_ready));
            chk("m_busy", 128'(busy), 128'(m_busy));
            chk("m_err", 128'(err), 128'(m_err));
            xfer = (idx >= 0) && fifo_nfull;
            if (xfer) m_ptr = idx;
            if (CREDIT) begin
                if (resp_valid) begin
                    if (int'(resp_id) >= NR) m_err = 1'b1;
                    else begin
                        if (m_cnt[resp_id] == 0) m_err = 1'b1;
                        if (!(xfer && idx == int'(resp_id)) && m_cnt[resp_id] > 0)
                            m_cnt[resp_id] = m_cnt[resp_id] - 1;
                    end
                end
                if (xfer && !(resp_valid && int'(resp_id) == idx)) m_cnt[idx] = m_cnt[idx] + 1;
            end
        end
    end

    initial begin
        logic [IW-1:0] e;
        logic [NR-1:0] mix_v  [7];
        logic          mix_nf [7];
        mix_v  = '{4'b1010, 4'b1010, 4'b0110, 4'b0110, 4'b1001, 4'b1111, 4'b0000};
        mix_nf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        req_data = '0;
        set_data();
        do_reset();

        // Reset state with idle inputs
        drive('0, 1'b1, 1'b0, 0);
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_fifo_valid", 128'(fifo_valid), 128'(0));
        chk("rst_fifo_data", 128'(fifo_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));

        // Fairness: 0,1,2,3,0,1
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive(4'b1111, 1'b1, 1'b0, 0);
            chk("fair_ready", 128'(req_ready), 128'(NR'(1) << e));
            chk("fair_tag", 128'(fifo_data[DW +: IW]), 128'(e));
        end

        // Back-pressure holds requester 2's grant
        repeat (3) begin
            drive(4'b1111, 1'b0, 1'b0, 0);
            chk("bp_valid", 128'(fifo_valid), 128'(1));
            chk("bp_ready", 128'(req_ready), 128'(0));
            chk("bp_tag", 128'(fifo_data[DW +: IW]), 128'(2));
        end
        drive(4'b1111, 1'b1, 1'b0, 0);
        chk("bp_release_ready", 128'(req_ready), 128'(4'b0100));
        chk("bp_release_data", 128'(fifo_data[DW-1:0]), 128'(dvals[2]));
        drive(4'b1111, 1'b1, 1'b0, 0);
        chk("bp_next_ready", 128'(req_ready), 128'(4'b1000));

`ifdef DIV_ARB_CREDIT_EN
        for (int i = 0; i < NR; i++) repeat (2) drive('0, 1'b1, 1'b1, i);
        drive('0, 1'b1, 1'b0, 0);
        chk("drain_busy", 128'(busy), 128'(0));
        chk("drain_err", 128'(err), 128'(0));
        repeat (3) begin
            drive(4'b0010, 1'b1, 1'b0, 0);
            chk("cap_ready", 128'(req_ready), 128'(4'b0010));
        end
        drive(4'b0010, 1'b1, 1'b0, 0);
        chk("cap_block_ready", 128'(req_ready), 128'(0));
        chk("cap_block_valid", 128'(fifo_valid), 128'(0));
        chk("cap_busy", 128'(busy), 128'(1));
        drive(4'b0010, 1'b1, 1'b1, 1);
        chk("cap_resp_cycle", 128'(req_ready), 128'(0));
        drive(4'b0010, 1'b1, 1'b0, 0);
        chk("cap_after_resp", 128'(req_ready), 128'(4'b0010));
        drive(4'b0010, 1'b1, 1'b0, 0);
        chk("cap_full_again", 128'(req_ready), 128'(0));
        repeat (3) drive('0, 1'b1, 1'b1, 1);
        drive(4'b0001, 1'b1, 1'b0, 0);
        chk("sim_first", 128'(req_ready), 128'(4'b0001));
        drive(4'b0001, 1'b1, 1'b1, 0);
        chk("sim_both", 128'(req_ready), 128'(4'b0001));
        drive('0, 1'b1, 1'b0, 0);
        chk("sim_busy", 128'(busy), 128'(1));
        chk("sim_err", 128'(err), 128'(0));
        drive('0, 1'b1, 1'b1, 0);
        drive('0, 1'b1, 1'b0, 0);
        chk("sim_idle_busy", 128'(busy), 128'(0));
        drive('0, 1'b1, 1'b1, 3);
        repeat (3) begin
            drive('0, 1'b1, 1'b0, 0);
            chk("err_sticky", 128'(err), 128'(1));
        end
        // Mid-operation reset, then a stale response
        drive(4'b0001, 1'b1, 1'b0, 0);
        do_reset();
        drive('0, 1'b1, 1'b0, 0);
        chk("rst2_busy", 128'(busy), 128'(0));
        chk("rst2_err", 128'(err), 128'(0));
        drive('0, 1'b1, 1'b1, 0);
        drive('0, 1'b1, 1'b0, 0);
        chk("stale_err", 128'(err), 128'(1));
`else
        for (int k = 0; k < 10; k++) begin
            drive(4'b0010, 1'b1, (k == 4), 1);
            chk("nocap_ready", 128'(req_ready), 128'(4'b0010));
            chk("nocap_busy", 128'(busy), 128'(0));
            chk("nocap_err", 128'(err), 128'(0));
        end
`endif

        // Mixed patterns checked by the model only
        set_data();
        for (int k = 0; k < 7; k++) drive(mix_v[k], mix_nf[k], 1'b0, 0);
        drive('0, 1'b1, 1'b0, 0);
        model_on = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
